call_scheduler: RTL and testbench

//  Upstream stage of car_indicator: collects floor-call button pulses, holds them as pending

---
 rtl/elevator_pkg.sv | 14 +
 rtl/floor_select.sv | 38 +++
 rtl/call_scheduler.sv | 125 ++++++++++++
 tb/tb_call_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor count, floor index width and the scan direction encoding.
// Also used by car_indicator, so the location width must stay in step with FW.
package elevator_pkg;

    localparam int NFLOORS = 8;
    localparam int FW      = 3;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

endpackage

// File: rtl/floor_select.sv
// Finds the nearest pending call at or above the car and the nearest one at or below it.
// Purely combinational masked priority encoders.
module floor_select
    import elevator_pkg::*;
#(
    parameter int NFLOORS_P = NFLOORS,
    parameter int FW_P      = FW
) (
    input  logic [NFLOORS_P-1:0] pending_i,
    input  logic [FW_P-1:0]      location_i,
    output logic [FW_P-1:0]      above_o,
    output logic                 above_hit_o,
    output logic [FW_P-1:0]      below_o,
    output logic                 below_hit_o
);

    always_comb begin
        // NOTE: every output gets a default before the loops so no latch is inferred.
        above_o     = '0;
        above_hit_o = 1'b0;
        below_o     = '0;
        below_hit_o = 1'b0;
        // Scanning downwards lets the lowest qualifying index be the last one written.
        for (int i = NFLOORS_P - 1; i >= 0; i--) begin
            if (pending_i[i] && (i >= int'(location_i))) begin
                above_o     = FW_P'(i);
                above_hit_o = 1'b1;
            end
        end
        for (int i = 0; i < NFLOORS_P; i++) begin
            if (pending_i[i] && (i <= int'(location_i))) begin
                below_o     = FW_P'(i);
                below_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_scheduler.sv
// Latches floor calls as pending requests and picks the next destination with a SCAN policy.
// Pending bits double as the call lamps.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int NFLOORS_P = NFLOORS,
    parameter int FW_P      = FW
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [NFLOORS_P-1:0] call,
    input  logic [FW_P-1:0]      location,
    input  logic                 door_open,
    output logic [NFLOORS_P-1:0] pending,
    output logic [FW_P-1:0]      dest,
    output logic                 dest_valid,
    output logic [1:0]           dir
);

    logic [NFLOORS_P-1:0] pending_q, pending_d, served;
    logic [FW_P-1:0]      dest_q, dest_d;
    logic                 valid_q, valid_d;
    dir_e                 dir_q, dir_d;

    logic [FW_P-1:0]      above, below;
    logic                 above_hit, below_hit;

    // An out-of-range location matches no bit, so nothing is served there.
    always_comb begin
        served = '0;
        for (int i = 0; i < NFLOORS_P; i++) begin
            served[i] = door_open && (int'(location) == i);
        end
    end

    // Clear beats set: a call at the open-door floor is absorbed immediately.
    assign pending_d = (pending_q | call) & ~served;

    floor_select #(
        .NFLOORS_P (NFLOORS_P),
        .FW_P      (FW_P)
    ) u_floor_select (
        .pending_i   (pending_q),
        .location_i  (location),
        .above_o     (above),
        .above_hit_o (above_hit),
        .below_o     (below),
        .below_hit_o (below_hit)
    );

    always_comb begin
        dir_d   = dir_q;
        dest_d  = dest_q;
        valid_d = valid_q;
        if (enable) begin
            unique case (dir_q)
                DIR_IDLE: begin
                    if (above_hit) begin
                        dest_d  = above;
                        valid_d = 1'b1;
                        dir_d   = (above == location) ? DIR_IDLE : DIR_UP;
                    end else if (below_hit) begin
                        dest_d  = below;
                        valid_d = 1'b1;
                        dir_d   = DIR_DOWN;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                DIR_UP: begin
                    if (above_hit) begin
                        dest_d  = above;
                        valid_d = 1'b1;
                    end else if (below_hit) begin
                        dest_d  = below;
                        valid_d = 1'b1;
                        dir_d   = DIR_DOWN;
                    end else begin
                        valid_d = 1'b0;
                        dir_d   = DIR_IDLE;
                    end
                end
                DIR_DOWN: begin
                    if (below_hit) begin
                        dest_d  = below;
                        valid_d = 1'b1;
                    end else if (above_hit) begin
                        dest_d  = above;
                        valid_d = 1'b1;
                        dir_d   = DIR_UP;
                    end else begin
                        valid_d = 1'b0;
                        dir_d   = DIR_IDLE;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    dir_d   = DIR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (!resetn) begin
            pending_q <= '0;
            dest_q    <= '0;
            valid_q   <= 1'b0;
            dir_q     <= DIR_IDLE;
        end else begin
            pending_q <= pending_d;
            dest_q    <= dest_d;
            valid_q   <= valid_d;
            dir_q     <= dir_d;
        end
    end

    assign pending    = pending_q;
    assign dest       = dest_q;
    assign dest_valid = valid_q;
    assign dir        = dir_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler: hand-computed expectations checked one step at a time.
module tb_call_scheduler;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic [7:0] call;
    logic [2:0] location;
    logic       door_open;
    logic [7:0] pending;
    logic [2:0] dest;
    logic       dest_valid;
    logic [1:0] dir;

    int checks = 0;
    int errors = 0;

    call_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .call       (call),
        .location   (location),
        .door_open  (door_open),
        .pending    (pending),
        .dest       (dest),
        .dest_valid (dest_valid),
        .dir        (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] p, input logic [2:0] d,
                             input logic v, input logic [1:0] r);
        check({tag, ".pending"}, 32'(pending), 32'(p));
        check({tag, ".dest"}, 32'(dest), 32'(d));
        check({tag, ".dest_valid"}, 32'(dest_valid), 32'(v));
        check({tag, ".dir"}, 32'(dir), 32'(r));
    endtask

    initial begin
        resetn    = 1'b0;
        enable    = 1'b1;
        call      = 8'h00;
        location  = 3'd0;
        door_open = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        check_all("reset", 8'h00, 3'd0, 1'b0, 2'b00);

        // Single call above an idle car at floor 0.
        call = 8'h10;
        tick();
        check("t2.pending", 32'(pending), 32'h10);
        check("t2.valid_early", 32'(dest_valid), 32'h0);
        call = 8'h00;
        tick();
        check_all("t2", 8'h10, 3'd4, 1'b1, 2'b01);

        // Serve floor 4 while floor 6 is called, then head up from floor 2 toward 6.
        location  = 3'd4;
        door_open = 1'b1;
        call      = 8'h40;
        tick();
        check("t3.setup_pending", 32'(pending), 32'h40);
        door_open = 1'b0;
        location  = 3'd2;
        call      = 8'h00;
        tick();
        check_all("t3.setup", 8'h40, 3'd6, 1'b1, 2'b01);
        // Nearer call ahead (4) and one behind (1) arrive together.
        call = 8'h12;
        tick();
        check_all("t3.latch", 8'h52, 3'd6, 1'b1, 2'b01);
        call = 8'h00;
        tick();
        check_all("t3.retarget", 8'h52, 3'd4, 1'b1, 2'b01);

        // Arrive at 4, then 6, reverse down to 1, then go idle.
        location  = 3'd4;
        door_open = 1'b1;
        tick();
        check("t4.clear4", 32'(pending), 32'h42);
        tick();
        check_all("t4.to6", 8'h42, 3'd6, 1'b1, 2'b01);
        location = 3'd6;
        tick();
        check("t4.clear6", 32'(pending), 32'h02);
        tick();
        check_all("t4.reverse", 8'h02, 3'd1, 1'b1, 2'b10);
        location = 3'd1;
        tick();
        check("t4.clear1", 32'(pending), 32'h00);
        tick();
        check_all("t4.idle", 8'h00, 3'd1, 1'b0, 2'b00);

        // Call at the open-door floor is absorbed.
        location  = 3'd3;
        door_open = 1'b1;
        call      = 8'h08;
        tick();
        check("t5.absorbed", 32'(pending), 32'h00);
        call = 8'h00;
        tick();
        check_all("t5", 8'h00, 3'd1, 1'b0, 2'b00);
        door_open = 1'b0;

        // Decisions frozen while disabled; pending still latches.
        enable = 1'b0;
        call   = 8'h80;
        tick();
        check("t6.latch", 32'(pending), 32'h80);
        call = 8'h00;
        tick();
        check_all("t6.frozen", 8'h80, 3'd1, 1'b0, 2'b00);
        enable = 1'b1;
        tick();
        check_all("t6.resume", 8'h80, 3'd7, 1'b1, 2'b01);

        // Serve 7 and drop to idle, then a call at the car's own floor keeps it idle.
        location  = 3'd7;
        door_open = 1'b1;
        tick();
        tick();
        check_all("t7.idle", 8'h00, 3'd7, 1'b0, 2'b00);
        door_open = 1'b0;
        location  = 3'd3;
        call      = 8'h08;
        tick();
        call = 8'h00;
        tick();
        check_all("t7.at_loc", 8'h08, 3'd3, 1'b1, 2'b00);

        // Calls on both sides from idle: up is preferred.
        door_open = 1'b1;
        call      = 8'h22;
        tick();
        check("t8.pending", 32'(pending), 32'h22);
        call      = 8'h00;
        door_open = 1'b0;
        tick();
        check_all("t8.tie", 8'h22, 3'd5, 1'b1, 2'b01);

        // Asynchronous reset mid-activity, held 5 cycles with calls pressed.
        #2;
        resetn = 1'b0;
        call   = 8'hff;
        #1;
        check_all("t1.async", 8'h00, 3'd0, 1'b0, 2'b00);
        repeat (5) tick();
        check_all("t1.held", 8'h00, 3'd0, 1'b0, 2'b00);
        call   = 8'h00;
        resetn = 1'b1;
        tick();
        check_all("t1.release", 8'h00, 3'd0, 1'b0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
